// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and defaults for the convolution coprocessor sequencer.
package convolution_coprocessor_pkg;

    // Default X/Y memory address width; Z memory is one bit wider.
    localparam int unsigned ADDR_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StMac,
        StDrain,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/convolution_coprocessor_fsm.sv
// Sequencer for a 1-D full convolution Z = X * Y. For each output index n it clears the
// accumulator, sweeps k over Y while reading X[n-k], waits one cycle for the last product,
// then writes Z[n].
module convolution_coprocessor_fsm
    import convolution_coprocessor_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   sizeX_i,
    input  logic [ADDR_W:0]   sizeY_i,
    output logic [ADDR_W-1:0] memX_addr_o,
    output logic [ADDR_W-1:0] memY_addr_o,
    output logic [ADDR_W:0]   memZ_addr_o,
    output logic              memZ_we_o,
    output logic              acc_clr_o,
    output logic              acc_en_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0]   KOne = 1;
    localparam logic [ADDR_W+1:0] KTwo = 2;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   k_q, k_d;
    logic [ADDR_W:0]   size_x_q, size_x_d;
    logic [ADDR_W:0]   size_y_q, size_y_d;
    logic              acc_en_q;

    logic [ADDR_W+1:0] diff;
    logic              tap_valid;
    logic              k_last;
    logic              n_last;

    // Tap geometry: X index is n-k, computed one bit wider so k>n cannot alias a valid index.
    always_comb begin
        diff      = {1'b0, n_q} - {1'b0, k_q};
        tap_valid = (k_q <= n_q) && (diff < {1'b0, size_x_q});
        k_last    = (k_q == (size_y_q - KOne));
        n_last    = ({1'b0, n_q} == ({1'b0, size_x_q} + {1'b0, size_y_q} - KTwo));
    end

    // State, counters and latched sizes; acc_en is the tap-valid flag delayed to match
    // the one-cycle memory read latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            n_q      <= '0;
            k_q      <= '0;
            size_x_q <= '0;
            size_y_q <= '0;
            acc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            acc_en_q <= (state_q == StMac) && tap_valid;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        size_x_d    = size_x_q;
        size_y_d    = size_y_q;
        memX_addr_o = '0;
        memY_addr_o = '0;
        memZ_addr_o = '0;
        memZ_we_o   = 1'b0;
        acc_clr_o   = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    size_x_d = sizeX_i;
                    size_y_d = sizeY_i;
                    n_d      = '0;
                    k_d      = '0;
                    // Empty operand: nothing to write, finish straight away.
                    state_d  = ((sizeX_i == '0) || (sizeY_i == '0)) ? StDone : StClear;
                end
            end
            StClear: begin
                acc_clr_o = 1'b1;
                k_d       = '0;
                state_d   = StMac;
            end
            StMac: begin
                memY_addr_o = k_q[ADDR_W-1:0];
                memX_addr_o = diff[ADDR_W-1:0];
                k_d         = k_q + KOne;
                if (k_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StWrite;
            end
            StWrite: begin
                memZ_we_o   = 1'b1;
                memZ_addr_o = n_q;
                if (n_last) begin
                    state_d = StDone;
                end else begin
                    n_d     = n_q + KOne;
                    state_d = StClear;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign acc_en_o = acc_en_q;
    assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_convolution_coprocessor_fsm.sv
// Self-checking bench for the convolution sequencer: directed and random jobs compared
// against a behavioural model of the convolution schedule.
module tb_convolution_coprocessor_fsm;

    localparam int unsigned AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW:0]   sizeX_i = '0;
    logic [AW:0]   sizeY_i = '0;
    logic [AW-1:0] memX_addr_o;
    logic [AW-1:0] memY_addr_o;
    logic [AW:0]   memZ_addr_o;
    logic          memZ_we_o;
    logic          acc_clr_o;
    logic          acc_en_o;
    logic          busy_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;

    convolution_coprocessor_fsm #(
        .ADDR_W(AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .sizeX_i     (sizeX_i),
        .sizeY_i     (sizeY_i),
        .memX_addr_o (memX_addr_o),
        .memY_addr_o (memY_addr_o),
        .memZ_addr_o (memZ_addr_o),
        .memZ_we_o   (memZ_we_o),
        .acc_clr_o   (acc_clr_o),
        .acc_en_o    (acc_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Number of (x,y) pairs with x+y == n inside the operand bounds.
    function automatic int taps_for(input int n, input int sx, input int sy);
        int cnt = 0;
        for (int x = 0; x < sx; x++) begin
            for (int y = 0; y < sy; y++) begin
                if (x + y == n) cnt++;
            end
        end
        return cnt;
    endfunction

    function automatic int all_outs();
        return int'({memX_addr_o, memY_addr_o, memZ_addr_o, memZ_we_o, acc_clr_o,
                     acc_en_o, busy_o, done_o});
    endfunction

    // Runs one job from a negedge; optionally re-pulses start mid-run or aborts by reset.
    task automatic run_job(input int sx, input int sy, input bit repulse, input int abort_at);
        int nout;
        int lat;
        int w;
        int acc_cnt;
        int acc_total;
        int prev_x;
        int prev_y;
        nout      = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
        lat       = nout * (sy + 3) + 1;
        w         = 0;
        acc_cnt   = 0;
        acc_total = 0;
        prev_x    = 0;
        prev_y    = 0;
        start_i   = 1'b1;
        sizeX_i   = sx[AW:0];
        sizeY_i   = sy[AW:0];
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk_i);
            check_eq("busy", busy_o, 1);
            check_eq("done_timing", done_o, int'(cyc == lat));
            check_eq("excl", int'((int'(memZ_we_o) + int'(acc_clr_o) + int'(acc_en_o)
                                   + int'(done_o)) <= 1), 1);
            if (acc_en_o) begin
                acc_cnt++;
                acc_total++;
                check_eq("tap_sum", prev_x + prev_y, w);
                check_eq("tap_x_in", int'(prev_x < sx), 1);
                check_eq("tap_y_in", int'(prev_y < sy), 1);
            end
            if (memZ_we_o) begin
                check_eq("z_addr", memZ_addr_o, w);
                check_eq("acc_count", acc_cnt, taps_for(w, sx, sy));
                w++;
                acc_cnt = 0;
            end
            prev_x = memX_addr_o;
            prev_y = memY_addr_o;
            if (cyc == abort_at) begin
                rst_n_i = 1'b0;
                #1;
                check_eq("rst_outs", all_outs(), 0);
                @(negedge clk_i);
                check_eq("rst_no_done", done_o, 0);
                check_eq("rst_hold_outs", all_outs(), 0);
                rst_n_i = 1'b1;
                start_i = 1'b0;
                return;
            end
            if (cyc == 1) begin
                start_i = 1'b0;
                sizeX_i = 6'($urandom_range(0, 32));
                sizeY_i = 6'($urandom_range(0, 32));
            end
            if (repulse && cyc == 3) begin
                start_i = 1'b1;
                sizeX_i = 6'($urandom_range(5, 32));
                sizeY_i = 6'($urandom_range(5, 32));
            end
            if (repulse && cyc == 4) start_i = 1'b0;
        end
        check_eq("writes", w, nout);
        check_eq("acc_total", acc_total, sx * sy);
        @(negedge clk_i);
        check_eq("idle_busy", busy_o, 0);
        check_eq("done_once", done_o, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("reset_outs", all_outs(), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        run_job(3, 2, 1'b0, 0);
        run_job(1, 1, 1'b0, 0);
        run_job(0, 5, 1'b0, 0);
        run_job(4, 0, 1'b0, 0);
        run_job(0, 0, 1'b0, 0);
        run_job(3, 2, 1'b1, 0);
        run_job(32, 32, 1'b0, 10);
        run_job(2, 2, 1'b0, 0);
        run_job(32, 32, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            run_job(int'($urandom_range(0, 32)), int'($urandom_range(0, 32)), 1'b1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
